// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// FSM state encoding, the header marker nibble and a constant clog2 helper.
package uart_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_SEND      = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_WAIT_CLR  = 3'd4
  } state_t;

  // Upper nibble of the optional per-packet header byte.
  localparam logic [3:0] HDR_MARK = 4'hA;

  // Number of bits needed to hold values 0..value-1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Bundle of requester-side and uart_tx-side signals around the arbiter.
// The slave modport is the arbiter's view; the master modport is the
// environment that supplies requester bytes and the uart_tx Done flag.
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 4
);

  logic [N_REQ-1:0]   i_Req_Valid;
  logic [8*N_REQ-1:0] i_Req_Byte;
  logic [N_REQ-1:0]   i_Req_Last;
  logic [N_REQ-1:0]   o_Req_Ready;
  logic [N_REQ-1:0]   o_Grant;
  logic               o_Timeout;
  logic               o_Tx_DV;
  logic [7:0]         o_Tx_Byte;
  logic               i_Tx_Done;

  modport slave (
    input  i_Req_Valid,
    input  i_Req_Byte,
    input  i_Req_Last,
    input  i_Tx_Done,
    output o_Req_Ready,
    output o_Grant,
    output o_Timeout,
    output o_Tx_DV,
    output o_Tx_Byte
  );

  modport master (
    output i_Req_Valid,
    output i_Req_Byte,
    output i_Req_Last,
    output i_Tx_Done,
    input  o_Req_Ready,
    input  o_Grant,
    input  o_Timeout,
    input  o_Tx_DV,
    input  o_Tx_Byte
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin picker: rotates the request vector so the search starts just
// after the previous owner, takes the lowest set bit, then rotates the
// result back to an absolute one-hot index.
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDXW  = 2
) (
  input  logic [N_REQ-1:0] i_Req,
  input  logic [IDXW-1:0]  i_Last_Grant,
  output logic [N_REQ-1:0] o_Pick,
  output logic             o_Any_Req
);

  logic [2*N_REQ-1:0] w_Dbl;
  logic [2*N_REQ-1:0] w_Shift;
  logic [N_REQ-1:0]   w_Rot;
  int                 w_Start;
  int                 w_Enc;
  int                 w_Abs;

  // Rotate, priority-encode the lowest set bit, then unrotate to one-hot.
  always_comb begin
    w_Start = int'(i_Last_Grant) + 1;
    if (w_Start >= N_REQ) begin
      w_Start = 0;
    end
    w_Dbl   = {i_Req, i_Req};
    w_Shift = w_Dbl >> w_Start;
    w_Rot   = w_Shift[N_REQ-1:0];
    w_Enc   = 0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (w_Rot[i]) begin
        w_Enc = i;
      end
    end
    w_Abs = w_Enc + w_Start;
    if (w_Abs >= N_REQ) begin
      w_Abs = w_Abs - N_REQ;
    end
    o_Pick = '0;
    if (|w_Rot) begin
      o_Pick[w_Abs] = 1'b1;
    end
    o_Any_Req = |i_Req;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one uart_tx among N_REQ
// byte-stream requesters. A requester owns the transmitter from its first
// byte through the byte flagged last; an idle owner loses the grant after
// TIMEOUT_CLKS cycles without a valid byte.
// Optional build macro: UART_TX_ARBITER_HDR_EN -- prefixes every packet with
// a header byte {HDR_MARK, owner index}.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int TIMEOUT_CLKS = 1024
) (
  input  logic               i_Clock,
  input  logic               i_Rst_n,
  uart_tx_arbiter_if.slave   bus
);

  localparam int IDXW = (clog2(N_REQ) < 1) ? 1 : clog2(N_REQ);
  localparam int CNTW = (clog2(TIMEOUT_CLKS) < 1) ? 1 : clog2(TIMEOUT_CLKS);
  localparam logic [CNTW-1:0] CNT_MAX = CNTW'(TIMEOUT_CLKS - 1);
  localparam logic [IDXW-1:0] LAST_GRANT_RST = IDXW'(N_REQ - 1);

  state_t            r_State;
  state_t            w_State_Nxt;
  logic [N_REQ-1:0]  r_Grant;
  logic [N_REQ-1:0]  w_Grant_Nxt;
  logic [7:0]        r_Tx_Byte;
  logic [7:0]        w_Tx_Byte_Nxt;
  logic              r_Last;
  logic              w_Last_Nxt;
  logic              r_Timeout;
  logic              w_Timeout_Nxt;
  logic              r_Hdr_Pend;
  logic              w_Hdr_Pend_Nxt;
  logic [CNTW-1:0]   r_Cnt;
  logic [CNTW-1:0]   w_Cnt_Nxt;
  logic [IDXW-1:0]   r_Last_Grant;
  logic [IDXW-1:0]   w_Last_Grant_Nxt;

  logic [N_REQ-1:0]  w_Pick;
  logic              w_Any_Req;
  logic [N_REQ-1:0]  w_Ready;
  logic [IDXW-1:0]   w_Grant_Idx;
  logic [7:0]        w_Sel_Byte;
  logic              w_Sel_Last;
  logic              w_Gnt_Valid;
  logic              w_Handshake;
  logic              w_Expire;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDXW  (IDXW)
  ) u_rr_pick (
    .i_Req        (bus.i_Req_Valid),
    .i_Last_Grant (r_Last_Grant),
    .o_Pick       (w_Pick),
    .o_Any_Req    (w_Any_Req)
  );

  // Decode the one-hot owner into an index and mux out its byte and last flag.
  always_comb begin
    w_Grant_Idx = '0;
    w_Sel_Byte  = 8'h00;
    w_Sel_Last  = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (r_Grant[k]) begin
        w_Grant_Idx = IDXW'(k);
        w_Sel_Byte  = bus.i_Req_Byte[8*k +: 8];
        w_Sel_Last  = bus.i_Req_Last[k];
      end
    end
  end

  // Ready goes only to the owner, and only while a payload byte is wanted.
  always_comb begin
    w_Ready     = '0;
    if (r_State == ST_LOAD && !r_Hdr_Pend) begin
      w_Ready = r_Grant;
    end
    w_Gnt_Valid = |(r_Grant & bus.i_Req_Valid);
    w_Handshake = |(w_Ready & bus.i_Req_Valid);
    w_Expire    = (r_State == ST_LOAD) && !r_Hdr_Pend && !w_Gnt_Valid &&
                  (r_Cnt == CNT_MAX);
  end

  // Next-state and next-register values; a handshake beats a timeout expiry.
  always_comb begin
    w_State_Nxt      = r_State;
    w_Grant_Nxt      = r_Grant;
    w_Tx_Byte_Nxt    = r_Tx_Byte;
    w_Last_Nxt       = r_Last;
    w_Cnt_Nxt        = '0;
    w_Timeout_Nxt    = 1'b0;
    w_Last_Grant_Nxt = r_Last_Grant;
    w_Hdr_Pend_Nxt   = r_Hdr_Pend;
    case (r_State)
      ST_IDLE: begin
        if (w_Any_Req) begin
          w_Grant_Nxt = w_Pick;
          w_State_Nxt = ST_LOAD;
`ifdef UART_TX_ARBITER_HDR_EN
          w_Hdr_Pend_Nxt = 1'b1;
`else
          w_Hdr_Pend_Nxt = 1'b0;
`endif
        end
      end
      ST_LOAD: begin
        if (r_Hdr_Pend) begin
          w_Tx_Byte_Nxt  = {HDR_MARK, 4'(w_Grant_Idx)};
          w_Last_Nxt     = 1'b0;
          w_Hdr_Pend_Nxt = 1'b0;
          w_State_Nxt    = ST_SEND;
        end else if (w_Handshake) begin
          w_Tx_Byte_Nxt = w_Sel_Byte;
          w_Last_Nxt    = w_Sel_Last;
          w_State_Nxt   = ST_SEND;
        end else if (w_Expire) begin
          w_Timeout_Nxt    = 1'b1;
          w_Grant_Nxt      = '0;
          w_Last_Grant_Nxt = w_Grant_Idx;
          w_State_Nxt      = ST_IDLE;
        end else begin
          w_Cnt_Nxt = (r_Cnt == CNT_MAX) ? r_Cnt : r_Cnt + 1'b1;
        end
      end
      ST_SEND: begin
        w_State_Nxt = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (bus.i_Tx_Done) begin
          w_State_Nxt = ST_WAIT_CLR;
        end
      end
      ST_WAIT_CLR: begin
        if (!bus.i_Tx_Done) begin
          if (r_Last) begin
            w_Grant_Nxt      = '0;
            w_Last_Grant_Nxt = w_Grant_Idx;
            w_State_Nxt      = ST_IDLE;
          end else begin
            w_State_Nxt = ST_LOAD;
          end
        end
      end
      default: begin
        w_State_Nxt = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_State <= ST_IDLE;
    end else begin
      r_State <= w_State_Nxt;
    end
  end

  // Owner, outgoing byte, last flag, timeout counter and round-robin pointer.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_Grant      <= '0;
      r_Tx_Byte    <= 8'h00;
      r_Last       <= 1'b0;
      r_Cnt        <= '0;
      r_Timeout    <= 1'b0;
      r_Hdr_Pend   <= 1'b0;
      r_Last_Grant <= LAST_GRANT_RST;
    end else begin
      r_Grant      <= w_Grant_Nxt;
      r_Tx_Byte    <= w_Tx_Byte_Nxt;
      r_Last       <= w_Last_Nxt;
      r_Cnt        <= w_Cnt_Nxt;
      r_Timeout    <= w_Timeout_Nxt;
      r_Hdr_Pend   <= w_Hdr_Pend_Nxt;
      r_Last_Grant <= w_Last_Grant_Nxt;
    end
  end

  assign bus.o_Req_Ready = w_Ready;
  assign bus.o_Grant     = r_Grant;
  assign bus.o_Timeout   = r_Timeout;
  assign bus.o_Tx_DV     = (r_State == ST_SEND);
  assign bus.o_Tx_Byte   = r_Tx_Byte;

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one `uart_tx` transmitter among `N_REQ` byte-stream requesters using round-robin arbitration at packet granularity. A requester keeps the grant from its first byte through the byte flagged `last`, so packets are never interleaved on the serial line. The block sits between on-chip message sources (debug, status, telemetry) and the single `uart_tx` instance. It sequences `uart_tx` through its DV/Done handshake one byte at a time.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters, 2..16.
- `TIMEOUT_CLKS`, 1024: idle cycles allowed inside a packet before the grant is revoked; must be at least 2.

Ports:
- `i_Clock` in 1: system clock.
- `i_Rst_n` in 1: asynchronous active-low reset.
- `i_Req_Valid` in N_REQ: per-requester byte valid.
- `i_Req_Byte` in 8*N_REQ: per-requester byte; requester k uses bits [8k+7:8k].
- `i_Req_Last` in N_REQ: byte is the final byte of its packet.
- `o_Req_Ready` out N_REQ: byte accepted when Valid and Ready are both high on a clock edge.
- `o_Grant` out N_REQ: one-hot owner of the transmitter, or zero when no requester owns it.
- `o_Timeout` out 1: one-cycle pulse when a grant is revoked by timeout.
- `o_Tx_DV` out 1: connects to `uart_tx` `i_Tx_DV`.
- `o_Tx_Byte` out 8: connects to `uart_tx` `i_Tx_Byte`.
- `i_Tx_Done` in 1: driven by `uart_tx` `o_Tx_Done`. It is high for two consecutive cycles per byte.

## Operation
States: IDLE, LOAD, SEND, WAIT_DONE, WAIT_CLR.
- IDLE:
  - If any `i_Req_Valid` is high, the round-robin pick is registered into `o_Grant` and the state moves to LOAD.
  - The search starts at index last_grant+1 and wraps modulo N_REQ.
- LOAD:
  - `o_Req_Ready[g]` is high combinationally for the granted index g only.
  - On the handshake, the byte goes into `o_Tx_Byte`, the `last` flag is latched, the timeout counter clears, and the state moves to SEND.
  - Valid bits from non-granted requesters are ignored.
- SEND:
  - `o_Tx_DV` is high for exactly this one cycle.
  - The state moves to WAIT_DONE.
- WAIT_DONE:
  - The state holds until `i_Tx_Done` is 1, then moves to WAIT_CLR.
- WAIT_CLR:
  - The state holds until `i_Tx_Done` is 0.
  - If the latched `last` flag is set, the state goes to IDLE, last_grant updates to g, and `o_Grant` clears.
  - Otherwise the state returns to LOAD.
  - This guarantees that `uart_tx` has returned to its idle state before the next DV.
- Timeout:
  - A counter runs only in LOAD while `i_Req_Valid[g]` is 0.
  - When it reaches TIMEOUT_CLKS-1, `o_Timeout` pulses, `o_Grant` clears, last_grant updates to g, and the state goes to IDLE.
- Counter width is clog2(TIMEOUT_CLKS). The counter saturates and never wraps.

## Timing
- Reset values:
  - State is IDLE.
  - `o_Grant`, `o_Req_Ready`, `o_Tx_DV`, `o_Timeout` are 0.
  - `o_Tx_Byte` is 8'h00.
  - last_grant is N_REQ-1, so requester 0 wins first.
  - The timeout counter is 0.
- Arbitration: Valid sampled in IDLE gives `o_Grant` one cycle later. Ready is asserted in that same cycle at the earliest.
- Handshake to DV latency is 1 cycle.
- Byte-to-byte gap: one full uart_tx frame, plus 3 cycles for the Done fall, plus 2 cycles for LOAD and SEND when data is waiting.
- A requester may drop Valid in the same cycle as Ready. It is not accepted.
- A requester that changes Byte while not Ready has no effect.
- If Valid and a timeout expiry land in the same cycle, the handshake wins and the counter clears.
- If reset asserts mid-packet, the state returns to IDLE immediately. Any byte in flight in `uart_tx` is abandoned by this block, and Done pulses are ignored until the next SEND.
- `i_Tx_Done` being high outside WAIT_DONE and WAIT_CLR is ignored.

## Configuration
- `UART_TX_ARBITER_HDR_EN` defined:
  - On entering LOAD from IDLE, the block first sends a header byte {4'hA, g[3:0]} through SEND, WAIT_DONE, and WAIT_CLR.
  - No requester handshake occurs for the header.
  - The timeout counter does not run during the header.
- `UART_TX_ARBITER_HDR_EN` undefined: no header; payload bytes only.

## Structure
- Package `uart_arb_pkg`:
  - state encoding constants;
  - `HDR_MARK` = 4'hA;
  - a clog2 function.
- Sub-module `rr_pick`:
  - combinational rotate–priority-encode–unrotate;
  - inputs: request vector and last_grant;
  - outputs: one-hot pick and any_req.
- The top level holds the FSM, the byte register, the last flag, and the timeout counter.

## Test plan
- Single packet, no header, requester 1 only:
  - Stimulus: requester 1 sends bytes 8'h55, 8'hA3 (last).
  - Required response: exactly two DV pulses with bytes 8'h55 then 8'hA3; `o_Grant` = 4'b0010 throughout; grant clears after the second Done falls.
- Contention:
  - Stimulus: requesters 0, 2, 3 each present a one-byte last packet (8'h10, 8'h12, 8'h13) at the same time after reset.
  - Required response: transmit order is 0, 2, 3; then a new packet from requester 0 wins only after 3.
- Packet atomicity:
  - Stimulus: requester 2 sends a 3-byte packet while requester 0 holds Valid continuously.
  - Required response: `o_Req_Ready[0]` stays 0 until requester 2's last byte completes.
- Timeout:
  - Setup: TIMEOUT_CLKS = 16.
  - Stimulus: requester 1 sends one non-last byte, then drops Valid.
  - Required response: `o_Timeout` pulses 16 cycles after LOAD is re-entered; grant passes to a waiting requester 2.
- Header (`UART_TX_ARBITER_HDR_EN` defined):
  - Stimulus: requester 3 sends 8'h42 (last).
  - Required response: DV bytes 8'hA3 then 8'h42.
- Reset mid-frame:
  - Stimulus: assert `i_Rst_n` = 0 during WAIT_DONE.
  - Required response: all outputs return to reset values asynchronously; no DV until a new Valid arrives.
